// File: rtl/mw_cla_adder_seq.sv
// Multi-word adder/subtractor: streams WORDS 32-bit slices, least-significant first,
// through one 32-bit carry-lookahead adder and chains the carry between cycles.

module CLA_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout,
    output logic        GP,
    output logic        GG
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic        gg_acc;

    assign g = A & B;
    assign p = A ^ B;

    // Two-level lookahead: 4-bit groups, then carries across the eight groups.
    always_comb begin
        grp_g  = '0;
        grp_p  = '0;
        grp_c  = '0;
        c      = '0;
        gg_acc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
        grp_c[0] = Cin;
        for (int k = 0; k < 8; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
            gg_acc     = grp_g[k] | (grp_p[k] & gg_acc);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k] = grp_c[k];
            for (int i = 0; i < 3; i++) begin
                c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
            end
        end
        c[32] = grp_c[8];
    end

    assign Sum  = p ^ c[31:0];
    assign Cout = c[32];
    assign GP   = &grp_p;
    assign GG   = gg_acc;
endmodule

module mw_cla_adder_seq #(
    parameter int WORDS = 4,
    parameter int IDXW  = $clog2(WORDS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    input  logic                cin,
    input  logic                op_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int W = 32 * WORDS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;

    logic [IDXW+4:0] bit_pos;
    logic [31:0]     slice_a;
    logic [31:0]     slice_b;
    logic [31:0]     slice_sum;
    logic            slice_cout;
    logic            slice_gp;
    logic            slice_gg;

    assign bit_pos = {idx, 5'd0};
    assign slice_a = 32'(a_q >> bit_pos);
    assign slice_b = 32'(b_q >> bit_pos);

    CLA_32bit u_cla (
        .A    (slice_a),
        .B    (slice_b),
        .Cin  (carry_q),
        .Sum  (slice_sum),
        .Cout (slice_cout),
        .GP   (slice_gp),
        .GG   (slice_gg)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Subtraction is A + ~B + ~borrow, so the operand and carry are inverted at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub ? ~cin : cin;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum     <= (sum & ~(W'(32'hFFFF_FFFF) << bit_pos))
                             | (W'(slice_sum) << bit_pos);
                    carry_q <= slice_cout;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= slice_cout;
                        ovf   <= (a_q[W-1] == b_q[W-1]) && (slice_sum[31] != a_q[W-1]);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mw_cla_adder_seq.sv
// Randomized self-checking bench for mw_cla_adder_seq against a wide-integer
// arithmetic model of add/subtract with carry, borrow and signed overflow.

module tb_mw_cla_adder_seq;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    mw_cla_adder_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: plain wide-integer arithmetic on the true values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mci, input logic msub);
        logic [W:0]          u;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        logic signed [W+1:0] sc;
        logic signed [W+1:0] r;
        sa = {{2{ma[W-1]}}, ma};
        sb = {{2{mb[W-1]}}, mb};
        sc = (W+2)'(mci);
        if (msub) begin
            u        = {1'b0, ma} - {1'b0, mb} - (W+1)'(mci);
            exp_cout = ~u[W];
            r        = sa - sb - sc;
        end else begin
            u        = {1'b0, ma} + {1'b0, mb} + (W+1)'(mci);
            exp_cout = u[W];
            r        = sa + sb + sc;
        end
        exp_sum = u[W-1:0];
        exp_ovf = (r != {{2{r[W-1]}}, r[W-1:0]});
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tci, input logic tsub);
        model(ta, tb_v, tci, tsub);
        @(negedge clk);
        check("in_ready_idle", W'(in_ready), W'(1'b1));
        a        = ta;
        b        = tb_v;
        cin      = tci;
        op_sub   = tsub;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(WORDS));
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_cout"}, W'(cout), W'(exp_cout));
        check({tag, "_ovf"}, W'(ovf), W'(exp_ovf));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, W'(out_valid), W'(1'b0));
        check({tag, "_ready_rise"}, W'(in_ready), W'(1'b1));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tci, input logic tsub);
        issue(ta, tb_v, tci, tsub);
        wait_result(tag);
        consume(tag);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[32*i +: 32] = rand_word();
        return v;
    endfunction

    logic [W-1:0] ones;
    logic [W-1:0] smax;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    initial begin
        ones      = '1;
        smax      = {1'b0, {(W-1){1'b1}}};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op_sub    = 1'b0;

        #12;
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(1'b0));
        check("rst_ovf", W'(ovf), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        do_op("max_plus1", ones, W'(1), 1'b0, 1'b0);
        check("max_plus1_const", sum, '0);
        do_op("chain", {32'h0, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF}, '0, 1'b1, 1'b0);
        check("chain_const", sum, {32'h1, 96'h0});
        do_op("sub5m7", W'(5), W'(7), 1'b0, 1'b1);
        check("sub5m7_const", sum, ones - W'(1));
        do_op("sub7m5b", W'(7), W'(5), 1'b1, 1'b1);
        check("sub7m5b_const", W'(cout), W'(1'b1));
        do_op("ovf_add", smax, W'(1), 1'b0, 1'b0);
        check("ovf_add_const", W'(ovf), W'(1'b1));
        do_op("ovf_sub", ~smax, W'(1), 1'b0, 1'b1);
        check("ovf_sub_const", sum, smax);

        // Backpressure: result must hold and new operands must be ignored.
        issue(rand_operand(), rand_operand(), 1'b1, 1'b0);
        wait_result("bp");
        held_sum  = sum;
        held_cout = cout;
        held_ovf  = ovf;
        for (int i = 0; i < 10; i++) begin
            a        = rand_operand();
            b        = rand_operand();
            op_sub   = 1'(i);
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_valid", W'(out_valid), W'(1'b1));
            check("bp_ready", W'(in_ready), W'(1'b0));
            check("bp_sum", sum, held_sum);
            check("bp_cout", W'(cout), W'(held_cout));
            check("bp_ovf", W'(ovf), W'(held_ovf));
        end
        in_valid = 1'b0;
        consume("bp");
        do_op("after_bp", rand_operand(), rand_operand(), 1'b0, 1'b1);

        // Asynchronous reset two RUN edges into an operation.
        @(negedge clk);
        a        = ones;
        b        = ones;
        cin      = 1'b1;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", W'(out_valid), W'(1'b0));
        check("mid_rst_in_ready", W'(in_ready), W'(1'b1));
        check("mid_rst_sum", sum, '0);
        check("mid_rst_cout", W'(cout), W'(1'b0));
        check("mid_rst_ovf", W'(ovf), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_rst", W'(1), W'(1), 1'b0, 1'b0);
        check("post_rst_const", sum, W'(2));

        for (int i = 0; i < 40; i++) begin
            issue(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            wait_result("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand_hold_sum", sum, exp_sum);
            consume("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
